tt_um_led_pwm_jellyant: RTL and testbench
=========================================

// Module: tt_um_led_pwm_jellyant
// PURPOSE
//  Parametrised multi-channel LED driver: next generation of our single-pin LED inverter top.
//  Each channel holds a duty/mode register written over the dedicated pins and drives one uo_out bit
//  with PWM, inverted PWM or blink. Duty changes are glitch-free: applied only at a PWM period boundary.
//  Tiny Tapeout user top; uio is all input.
// PARAMETERS
//  CH     8  channels driven, 1..8; uo_out[7:CH] tied 0
//  PWM_W  8  PWM counter/duty width, 1..8; period = PRESC * 2^PWM_W clk cycles
//  PRESC  4  prescaler divide, >=1; PWM counter advances once per PRESC cycles
// PORTS
//  clk      in   1  single clock
//  rst_n    in   1  reset, synchronous, active-low
//  ena      in   1  always 1; unused
//  ui_in    in   8  [2:0] addr, [4:3] mode, [5] global enable, [6] unused, [7] write strobe
//  uio_in   in   8  duty value; bits [PWM_W-1:0] used
//  uo_out   out  8  registered channel outputs, bit n = channel n
//  uio_out  out  8  constant 0
//  uio_oe   out  8  constant 0 (all uio inputs)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): prescaler=0, pwm_cnt=0, blink_q=0, all shadow/active duty=0,
//   all modes OFF, uo_out=0, strobe_q=1 (strobe held high across reset is NOT a write).
//  Write: posedge where ui_in[7]=1 and strobe_q=0. If addr<CH, shadow_duty[addr]<=uio_in[PWM_W-1:0]
//   and mode[addr]<=ui_in[4:3] at that edge; addr>=CH ignored. Mode takes effect next cycle.
//  Tick: prescaler counts 0..PRESC-1, tick when ==PRESC-1 (PRESC=1: every cycle). pwm_cnt++ on tick, wraps.
//  Wrap: tick with pwm_cnt==2^PWM_W-1: every active_duty<=shadow_duty; blink_q toggles.
//   Write and wrap same cycle: active takes the pre-write shadow; new value applies next wrap.
//  Modes: 00 OFF out=0; 01 PWM out=(pwm_cnt<active); 10 INV out=!(pwm_cnt<active);
//   11 BLINK out=blink_q & (active!=0).
//   Edges: PWM duty 0 always 0, duty max low 1 count/period; INV duty 0 always 1.
//  ui_in[5]=0 forces uo_out to 0 next cycle; counters and registers keep running. Level, not latched.
//  uo_out registered: 1 cycle after the pwm_cnt/mode/enable state it reflects.
//  Compare unsigned, PWM_W bits.
// STRUCTURE
//  Package led_pwm_pkg: mode localparams (OFF/PWM/INV/BLINK), ui_in field positions, mode width.
//  Sub-module led_pwm_channel: shadow/active duty, mode, compare -> 1-bit out; generate CH copies.
//  Top: strobe edge detect, address decode, prescaler, pwm_cnt, blink_q, enable gating, output regs.
// TESTING (PRESC=1, PWM_W=8, CH=4 unless noted)
//  Reset with ui_in[7]=1 held through release -> uo_out=0, no write, all modes OFF after.
//  Write ch0 duty 64 PWM, en=1 -> from next wrap, uo_out[0] high 64 of every 256 cycles.
//  ch0 PWM duty 0 -> always 0; INV duty 0 -> always 1; PWM duty 255 -> low exactly 1 cycle/period.
//  ch1 at 128, write 32 mid-period and on the wrap cycle -> current period 128 high, then 32.
//  Write addr 7 duty 200 PWM -> no uo_out bit changes; uo_out[7:4] always 0.
//  ch2 BLINK duty 1 -> toggles every 256 cycles; en=0 -> uo_out=0 next cycle; rst_n mid-period -> all 0.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared definitions for the multi-channel LED PWM driver: channel modes and ui_in field layout.
package led_pwm_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'b00,
    MODE_PWM   = 2'b01,
    MODE_INV   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  localparam int UI_ADDR_LO = 0;
  localparam int UI_ADDR_HI = 2;
  localparam int UI_MODE_LO = 3;
  localparam int UI_MODE_HI = 4;
  localparam int UI_EN      = 5;
  localparam int UI_STROBE  = 7;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active duty, mode register and the compare that yields its output bit.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             wrap,
  input  logic [PWM_W-1:0] duty,
  input  mode_e            mode_in,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             blink_q,
  output logic             out
);

  logic [PWM_W-1:0] shadow_duty;
  logic [PWM_W-1:0] active_duty;
  mode_e            mode;
  logic             below;

  // NOTE: these are a handful of flops, not a RAM, so every one gets a reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_duty <= '0;
      active_duty <= '0;
      mode        <= MODE_OFF;
    end else begin
      if (we) begin
        shadow_duty <= duty;
        mode        <= mode_in;
      end
      // A write landing on the wrap edge is not seen here until the following wrap.
      if (wrap) active_duty <= shadow_duty;
    end
  end

  assign below = (pwm_cnt < active_duty);

  // NOTE: out is assigned before the case so no path leaves it unassigned (no latch).
  always_comb begin
    out = 1'b0;
    unique case (mode)
      MODE_OFF:   out = 1'b0;
      MODE_PWM:   out = below;
      MODE_INV:   out = ~below;
      MODE_BLINK: out = blink_q & (active_duty != '0);
      default:    out = 1'b0;
    endcase
  end

endmodule

// File: rtl/tt_um_led_pwm_jellyant.sv
// Tiny Tapeout top: strobe-written per-channel LED registers driving uo_out with PWM/INV/BLINK.
module tt_um_led_pwm_jellyant
  import led_pwm_pkg::*;
#(
  parameter int CH    = 8,
  parameter int PWM_W = 8,
  parameter int PRESC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int                 PRESC_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
  localparam logic [PWM_W-1:0]   CNT_MAX    = '1;

  logic               strobe_q;
  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               blink_q;
  logic [7:0]         uo_q;
  logic [7:0]         ch_out;
  logic [CH-1:0]      ch_bits;
  logic               write;
  logic               tick;
  logic               wrap;
  logic [2:0]         addr;
  mode_e              mode_in;
  logic               unused_ok;

  assign write   = ui_in[UI_STROBE] & ~strobe_q;
  assign tick    = (presc == PRESC_LAST);
  assign wrap    = tick & (pwm_cnt == CNT_MAX);
  assign addr    = ui_in[UI_ADDR_HI:UI_ADDR_LO];
  assign mode_in = mode_e'(ui_in[UI_MODE_HI:UI_MODE_LO]);

  // Addresses at or above CH match no channel, so those writes fall away.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    led_pwm_channel #(.PWM_W(PWM_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (write && (addr == 3'(i))),
      .wrap    (wrap),
      .duty    (uio_in[PWM_W-1:0]),
      .mode_in (mode_in),
      .pwm_cnt (pwm_cnt),
      .blink_q (blink_q),
      .out     (ch_bits[i])
    );
  end

  always_comb begin
    ch_out          = '0;
    ch_out[CH-1:0]  = ch_bits;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q <= 1'b1;  // a strobe held high through reset must not count as a write
      presc    <= '0;
      pwm_cnt  <= '0;
      blink_q  <= 1'b0;
      uo_q     <= '0;
    end else begin
      strobe_q <= ui_in[UI_STROBE];
      presc    <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) blink_q <= ~blink_q;
      uo_q     <= ui_in[UI_EN] ? ch_out : '0;
    end
  end

  assign uo_out    = uo_q;
  assign uio_out   = '0;
  assign uio_oe    = '0;
  assign unused_ok = &{1'b0, ena, ui_in[6], uio_in};

endmodule

// File: tb/tb_tt_um_led_pwm_jellyant.sv
// Scoreboard bench for tt_um_led_pwm_jellyant with CH=4, PWM_W=8, PRESC=1.
module tb_tt_um_led_pwm_jellyant;

  localparam int CH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_shadow[CH];
  logic [7:0] m_active[CH];
  logic [1:0] m_mode[CH];
  logic [7:0] m_cnt;
  logic       m_blink;
  logic       m_strobe;
  logic [7:0] last_uo;

  always #5 clk = ~clk;

  tt_um_led_pwm_jellyant #(.CH(CH), .PWM_W(8), .PRESC(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    o = 8'h00;
    for (int c = 0; c < CH; c++) begin
      case (m_mode[c])
        2'b01:   o[c] = (m_cnt < m_active[c]);
        2'b10:   o[c] = !(m_cnt < m_active[c]);
        2'b11:   o[c] = m_blink && (m_active[c] != 8'h00);
        default: o[c] = 1'b0;
      endcase
    end
    return o;
  endfunction

  // One clock: predict the registered output, advance the model, then compare after the edge.
  task automatic tick();
    logic [7:0] want, got;
    logic       wr;
    int         a;
    if (!rst_n) want = 8'h00;
    else        want = ui_in[5] ? model_out() : 8'h00;
    exp_q.push_back(want);
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_shadow[c] = 8'h00; m_active[c] = 8'h00; m_mode[c] = 2'b00;
      end
      m_cnt = 8'h00; m_blink = 1'b0; m_strobe = 1'b1;
    end else begin
      wr = ui_in[7] && !m_strobe;
      if (m_cnt == 8'hFF) begin
        for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
        m_blink = !m_blink;
      end
      m_cnt = m_cnt + 8'd1;
      a = int'(ui_in[2:0]);
      if (wr && a < CH) begin
        m_shadow[a] = uio_in;
        m_mode[a]   = ui_in[4:3];
      end
      m_strobe = ui_in[7];
    end
    @(posedge clk);
    #1;
    got  = uo_out;
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL scoreboard uo_out at %0t: got %h expected %h", $time, got, want);
    end
    if ((uio_out !== 8'h00) || (uio_oe !== 8'h00)) begin
      errors++;
      $display("FAIL uio_tieoff at %0t: uio_out %h uio_oe %h expected 00", $time, uio_out, uio_oe);
    end
    last_uo = got;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_mask(input logic [7:0] mask, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if ((last_uo & mask) != 8'h00) cnt++;
    end
  endtask

  task automatic write_ch(input logic [2:0] addr, input logic [1:0] mode, input logic [7:0] duty);
    ui_in  = {1'b1, 1'b0, 1'b1, mode, addr};
    uio_in = duty;
    tick();
    ui_in[7] = 1'b0;
    tick();
  endtask

  task automatic to_wrap();
    int guard = 0;
    while (m_cnt != 8'hFF && guard < 300) begin
      tick();
      guard++;
    end
    if (m_cnt != 8'hFF) begin
      errors++;
      $display("FAIL to_wrap: counter %0d never reached 255", m_cnt);
    end
  endtask

  task automatic expect_count(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: counted %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hA8;   // strobe, en, PWM, addr 0
    uio_in = 8'hAA;
    run(3);
    expect_count("reset_uo_zero", int'(last_uo), 0);
    rst_n = 1'b1;
    run(2);
    ui_in = 8'h28;
    count_mask(8'hFF, 600, c);
    expect_count("reset_strobe_no_write", c, 0);
  endtask

  task automatic test_pwm64();
    int c;
    write_ch(3'd0, 2'b01, 8'd64);
    run(300);
    count_mask(8'h01, 256, c);
    expect_count("pwm_duty64", c, 64);
  endtask

  task automatic test_edges();
    int c;
    write_ch(3'd0, 2'b01, 8'd0);
    run(300);
    count_mask(8'h01, 256, c);
    expect_count("pwm_duty0", c, 0);
    write_ch(3'd0, 2'b10, 8'd0);
    run(300);
    count_mask(8'h01, 256, c);
    expect_count("inv_duty0", c, 256);
    write_ch(3'd0, 2'b01, 8'd255);
    run(300);
    count_mask(8'h01, 256, c);
    expect_count("pwm_duty255", c, 255);
  endtask

  task automatic test_duty_update();
    int c;
    write_ch(3'd1, 2'b01, 8'd128);
    run(300);
    to_wrap();
    tick();
    run(100);
    write_ch(3'd1, 2'b01, 8'd32);
    to_wrap();
    tick();
    count_mask(8'h02, 256, c);
    expect_count("mid_period_write_next", c, 32);
    write_ch(3'd1, 2'b01, 8'd128);
    run(300);
    to_wrap();
    ui_in  = {1'b1, 1'b0, 1'b1, 2'b01, 3'd1};
    uio_in = 8'd32;
    tick();
    ui_in[7] = 1'b0;
    count_mask(8'h02, 256, c);
    expect_count("wrap_write_current", c, 128);
    count_mask(8'h02, 256, c);
    expect_count("wrap_write_next", c, 32);
  endtask

  task automatic test_bad_addr();
    int c;
    write_ch(3'd7, 2'b01, 8'd200);
    count_mask(8'hF0, 300, c);
    expect_count("bad_addr_upper_zero", c, 0);
  endtask

  task automatic test_blink();
    int   len, guard;
    logic prev;
    write_ch(3'd2, 2'b11, 8'd1);
    run(300);
    prev  = last_uo[2];
    guard = 0;
    while (last_uo[2] == prev && guard < 600) begin tick(); guard++; end
    prev = last_uo[2];
    len  = 0;
    while (last_uo[2] == prev && len < 600) begin tick(); len++; end
    expect_count("blink_half_period", len, 256);
  endtask

  task automatic test_enable();
    ui_in[5] = 1'b0;
    tick();
    expect_count("enable_low_zero", int'(last_uo), 0);
    run(20);
    ui_in[5] = 1'b1;
    run(20);
  endtask

  task automatic test_reset_mid();
    int c;
    run(50);
    rst_n = 1'b0;
    tick();
    expect_count("reset_mid_zero", int'(last_uo), 0);
    rst_n = 1'b1;
    count_mask(8'hFF, 300, c);
    expect_count("reset_modes_off", c, 0);
  endtask

  initial begin
    test_reset();
    test_pwm64();
    test_edges();
    test_duty_update();
    test_bad_addr();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
